usb_host_xfer_ctrl: RTL and testbench

Parametrised host-side transfer controller, successor to the single-shot host wrapper. Accepts read/write page commands through a valid/ready queue, drives the protocol engine (start/finished/success handshake), retries failed or timed-out transactions, and returns one response per command. Sits between system logic and the packet-level read/write FSM that owns the DP/DM tristates.

---
 rtl/usb_host_xfer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_usb_host_xfer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_xfer_ctrl.sv
// Host transfer controller: command FIFO, engine handshake, retry/timeout, responses.
// Define USB_HOST_XFER_STATS_EN to add saturating ok/fail/retry counters.
module usb_host_xfer_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64,
    parameter int CMD_DEPTH   = 4,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [ADDR_W-1:0]              cmd_page,
    input  logic [DATA_W-1:0]              cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_success,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [$clog2(MAX_RETRY+2)-1:0] rsp_attempts,
    output logic                           eng_read_start,
    output logic                           eng_write_start,
    output logic                           eng_abort,
    output logic [ADDR_W-1:0]              eng_mempage,
    output logic [DATA_W-1:0]              eng_wdata,
    input  logic                           eng_finished,
    input  logic                           eng_read_success,
    input  logic                           eng_write_success,
    input  logic [DATA_W-1:0]              eng_rdata,
    output logic                           busy
`ifdef USB_HOST_XFER_STATS_EN
    ,
    output logic [15:0]                    stat_ok,
    output logic [15:0]                    stat_fail,
    output logic [15:0]                    stat_retry
`endif
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ATT_W = $clog2(MAX_RETRY + 2);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  page_q, page_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               succ_q, succ_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               push, pop, fail, abort;

    // Ready is registered, so a pop never lets a same-cycle push in when full.
    assign push        = cmd_valid && cmd_ready_q;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    assign cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH));

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_page, cmd_data};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            page_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            succ_q      <= 1'b0;
            att_q       <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            wr_q        <= wr_d;
            page_q      <= page_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            succ_q      <= succ_d;
            att_q       <= att_d;
            tmr_q       <= tmr_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        page_d  = page_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        succ_d  = succ_q;
        att_d   = att_q;
        tmr_d   = tmr_q;
        fail    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {wr_d, page_d, wdata_d} = mem_q[rd_ptr_q];
                    att_d   = ATT_W'(1);
                    succ_d  = 1'b0;
                    rdata_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_GUARD;
            end
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                // A finish in the timeout cycle takes priority over the abort.
                if (eng_finished) begin
                    if (wr_q ? eng_write_success : eng_read_success) begin
                        succ_d  = 1'b1;
                        rdata_d = wr_q ? '0 : eng_rdata;
                        state_d = S_RESP;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    abort = 1'b1;
                    fail  = 1'b1;
                end
                if (fail) begin
                    if (att_q <= ATT_W'(MAX_RETRY)) begin
                        att_d   = att_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        succ_d  = 1'b0;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_valid       = (state_q == S_RESP);
    assign rsp_success     = succ_q;
    assign rsp_data        = rdata_q;
    assign rsp_attempts    = att_q;
    assign eng_read_start  = (state_q == S_ISSUE) && !wr_q;
    assign eng_write_start = (state_q == S_ISSUE) && wr_q;
    assign eng_abort       = abort;
    assign eng_mempage     = page_q;
    assign eng_wdata       = wdata_q;
    assign cmd_ready       = cmd_ready_q;
    assign busy            = (state_q != S_IDLE) || (count_q != '0);

`ifdef USB_HOST_XFER_STATS_EN
    logic        retry_ev, rsp_fire;
    logic [15:0] ok_q, fail_q, retry_q;

    assign rsp_fire = rsp_valid && rsp_ready;
    assign retry_ev = (state_q == S_WAIT) && fail && (att_q <= ATT_W'(MAX_RETRY));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ok_q    <= '0;
            fail_q  <= '0;
            retry_q <= '0;
        end else begin
            if (rsp_fire && succ_q && ok_q != 16'hFFFF)     ok_q    <= ok_q + 1'b1;
            if (rsp_fire && !succ_q && fail_q != 16'hFFFF)  fail_q  <= fail_q + 1'b1;
            if (retry_ev && retry_q != 16'hFFFF)            retry_q <= retry_q + 1'b1;
        end
    end

    assign stat_ok    = ok_q;
    assign stat_fail  = fail_q;
    assign stat_retry = retry_q;
`endif
endmodule

// File: tb/tb_usb_host_xfer_ctrl.sv
// Directed bench for usb_host_xfer_ctrl with a scripted protocol-engine model.
// Runs with CMD_DEPTH=4, MAX_RETRY=3, TIMEOUT_CYC=16.
module tb_usb_host_xfer_ctrl;
    localparam int AW = 16;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_page;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid, rsp_ready, rsp_success;
    logic [DW-1:0] rsp_data;
    logic [2:0]    rsp_attempts;
    logic          eng_read_start, eng_write_start, eng_abort;
    logic [AW-1:0] eng_mempage;
    logic [DW-1:0] eng_wdata;
    logic          eng_finished, eng_read_success, eng_write_success;
    logic [DW-1:0] eng_rdata;
    logic          busy;

    usb_host_xfer_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(4), .MAX_RETRY(3), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_page(cmd_page), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_success(rsp_success),
        .rsp_data(rsp_data), .rsp_attempts(rsp_attempts),
        .eng_read_start(eng_read_start), .eng_write_start(eng_write_start),
        .eng_abort(eng_abort), .eng_mempage(eng_mempage), .eng_wdata(eng_wdata),
        .eng_finished(eng_finished), .eng_read_success(eng_read_success),
        .eng_write_success(eng_write_success), .eng_rdata(eng_rdata),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    // Engine script, written only by the main process.
    int          eng_delay;
    int          fail_n;
    int          fail_base;
    logic [63:0] rdata_val;
    bit          rdata_from_page;

    // Engine observations, written only by the engine process.
    int n_starts, n_wstart, n_rstart, n_abort, abort_gap;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: finish eng_delay cycles after the start pulse (0 = never);
    // the first fail_n attempts counted from fail_base report failure.
    initial begin
        bit pending;
        bit ok;
        int k, g;
        eng_finished = 1'b0;
        eng_read_success = 1'b0;
        eng_write_success = 1'b0;
        eng_rdata = '0;
        n_starts = 0; n_wstart = 0; n_rstart = 0; n_abort = 0; abort_gap = 0;
        pending = 1'b0; k = 0; g = 0;
        forever begin
            @(negedge clock);
            eng_finished = 1'b0;
            eng_read_success = 1'b0;
            eng_write_success = 1'b0;
            g++;
            if (!reset_n) begin
                pending = 1'b0;
            end else begin
                if (eng_abort) begin
                    n_abort++;
                    abort_gap = g;
                    pending = 1'b0;
                end
                if (pending) begin
                    k++;
                    if (k == eng_delay) begin
                        ok = (n_starts - fail_base) > fail_n;
                        eng_finished = 1'b1;
                        eng_read_success = ok;
                        eng_write_success = ok;
                        eng_rdata = rdata_from_page ? {48'h0, eng_mempage} : rdata_val;
                        pending = 1'b0;
                    end
                end
                if (eng_read_start || eng_write_start) begin
                    n_starts++;
                    if (eng_write_start) n_wstart++;
                    else n_rstart++;
                    g = 0;
                    k = 0;
                    pending = (eng_delay != 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic w, input logic [15:0] p, input logic [63:0] d);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_page  = p;
        cmd_data  = d;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int s0, w0, r0, a0, acc, idx, n;
        bit sampled, pend_acc, any_rsp;
        logic [63:0] exp_d;

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_page = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        eng_delay = 10; fail_n = 0; fail_base = 0;
        rdata_val = '0; rdata_from_page = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_read_start | eng_write_start, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_busy", busy, 0);

        // single write, engine finishes 10 cycles after start
        w0 = n_wstart; fail_base = n_starts; fail_n = 0; eng_delay = 10;
        push(1'b1, 16'h0001, 64'hDEADBEEF_CAFEF00D);
        chk("w_busy", busy, 1);
        wait_rsp(100);
        chk("w_success", rsp_success, 1);
        chk("w_attempts", rsp_attempts, 1);
        chk("w_data", rsp_data, 0);
        chk("w_mempage", eng_mempage, 16'h0001);
        chk("w_wdata", eng_wdata, 64'hDEADBEEF_CAFEF00D);
        chk("w_starts", 64'(n_wstart - w0), 1);
        ack();
        chk("w_idle_busy", busy, 0);

        // read with minimum latency
        r0 = n_rstart; w0 = n_wstart; fail_base = n_starts; eng_delay = 2;
        rdata_val = 64'h0123456789ABCDEF;
        push(1'b0, 16'h00A5, 64'h0);
        repeat (3) @(negedge clock);
        chk("lat_early", rsp_valid, 0);
        @(negedge clock);
        chk("lat5", rsp_valid, 1);
        chk("r_success", rsp_success, 1);
        chk("r_data", rsp_data, 64'h0123456789ABCDEF);
        chk("r_attempts", rsp_attempts, 1);
        chk("r_rstarts", 64'(n_rstart - r0), 1);
        chk("r_wstarts", 64'(n_wstart - w0), 0);
        ack();

        // two failures then success
        s0 = n_starts; fail_base = n_starts; fail_n = 2; eng_delay = 3;
        push(1'b1, 16'h0010, 64'h1111);
        wait_rsp(300);
        repeat (3) @(negedge clock);
        chk("retry_hold", rsp_valid, 1);
        chk("retry_success", rsp_success, 1);
        chk("retry_attempts", rsp_attempts, 3);
        chk("retry_starts", 64'(n_starts - s0), 3);
        ack();

        // every attempt fails
        s0 = n_starts; fail_base = n_starts; fail_n = 4;
        rdata_val = 64'hFFFF_FFFF_FFFF_FFFF;
        push(1'b0, 16'h0020, 64'h0);
        wait_rsp(300);
        chk("fail_success", rsp_success, 0);
        chk("fail_attempts", rsp_attempts, 4);
        chk("fail_data", rsp_data, 0);
        ack();
        repeat (10) @(negedge clock);
        chk("fail_starts", 64'(n_starts - s0), 4);

        // engine never finishes
        s0 = n_starts; a0 = n_abort; eng_delay = 0;
        push(1'b1, 16'h0030, 64'h2222);
        wait_rsp(500);
        chk("to_success", rsp_success, 0);
        chk("to_attempts", rsp_attempts, 4);
        chk("to_aborts", 64'(n_abort - a0), 4);
        chk("to_starts", 64'(n_starts - s0), 4);
        chk("to_gap", 64'(abort_gap), 17);
        ack();

        // FIFO fill while a response is held
        eng_delay = 2; fail_n = 0; fail_base = n_starts; rdata_from_page = 1'b1;
        push(1'b0, 16'h00FF, 64'h0);
        wait_rsp(50);
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_page  = 16'h0100 + 16'(acc);
            sampled   = cmd_ready;
            @(negedge clock);
            if (sampled) acc++;
        end
        chk("fifo_accepted", 64'(acc), 4);
        chk("fifo_full_ready", cmd_ready, 0);
        chk("fifo_busy", busy, 1);
        rsp_ready = 1'b1;
        idx = 0; n = 0;
        while (idx < 6 && n < 300) begin
            if (rsp_valid) begin
                exp_d = (idx == 0) ? 64'h00FF : 64'h0100 + 64'(idx - 1);
                chk($sformatf("fifo_order%0d", idx), rsp_data, exp_d);
                idx++;
            end
            pend_acc = cmd_valid && cmd_ready;
            @(negedge clock);
            n++;
            if (pend_acc) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        rdata_from_page = 1'b0;
        chk("fifo_nrsp", 64'(idx), 6);
        repeat (2) @(negedge clock);
        chk("fifo_drained", busy, 0);

        // reset during WAIT with two commands queued
        eng_delay = 0; s0 = n_starts; a0 = n_abort;
        push(1'b1, 16'h0040, 64'h40);
        push(1'b1, 16'h0041, 64'h41);
        push(1'b1, 16'h0042, 64'h42);
        repeat (4) @(negedge clock);
        chk("mid_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_page", eng_mempage, 0);
        chk("mid_rst_abort", eng_abort, 0);
        chk("mid_rst_att", rsp_attempts, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        any_rsp = 1'b0;
        repeat (40) begin
            @(negedge clock);
            any_rsp = any_rsp | rsp_valid;
        end
        chk("post_no_rsp", any_rsp, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", cmd_ready, 1);
        chk("post_starts", 64'(n_starts - s0), 1);
        chk("post_aborts", 64'(n_abort - a0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
